go_get_put_sequencer: RTL and testbench

//   Transaction sequencer that drives the go/get/put/stop handshake group.
//   A transaction is: one go pulse, then GET_CYCLES consecutive get cycles,

---
 rtl/go_get_put_if.sv | 40 ++++
 rtl/go_get_put_sequencer.sv | 159 +++++++++++++++
 tb/tb_go_get_put_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/go_get_put_if.sv
// go_get_put_if: handshake group between the transaction sequencer and the
// request source / shared get/put resource.
//
// Signals:
//   req        start request
//   put_rdy    downstream can accept a put beat this cycle
//   abort_req  request early termination
//   go         transaction start pulse
//   get        get phase active
//   put        put beat
//   stop       termination pulse
//   busy       sequencer not idle
//   done       completion pulse
//   err        watchdog-abort pulse
//
// Modports:
//   master  the sequencer side; drives go/get/put/stop/busy/done/err
//   slave   the environment side; drives req/put_rdy/abort_req
interface go_get_put_if;
  logic req;
  logic put_rdy;
  logic abort_req;
  logic go;
  logic get;
  logic put;
  logic stop;
  logic busy;
  logic done;
  logic err;

  modport master (
    input  req, put_rdy, abort_req,
    output go, get, put, stop, busy, done, err
  );

  modport slave (
    output req, put_rdy, abort_req,
    input  go, get, put, stop, busy, done, err
  );
endinterface

// File: rtl/go_get_put_sequencer.sv
// go_get_put_sequencer: drives one go pulse, GET_CYCLES consecutive get
// cycles and then PUT_COUNT put beats per transaction. stop stays low from
// the first get until the last put beat, then pulses with done.
//
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  go_get_put_if.master (req, put_rdy, abort_req in;
//        go, get, put, stop, busy, done, err out)
//
// Optional feature: define WATCHDOG_EN to abort a PUT phase that sees
// TIMEOUT consecutive cycles without put_rdy (stop and err pulse).
// Without it PUT waits indefinitely and err is tied low.
module go_get_put_sequencer #(
  parameter int GET_CYCLES = 2,
  parameter int PUT_COUNT  = 2,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 15
) (
  input logic            clk,
  input logic            rst,
  go_get_put_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GO    = 3'd1,
    GET   = 3'd2,
    PUT   = 3'd3,
    DONE  = 3'd4,
    ABORT = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] get_cnt;
  logic [CNT_W-1:0] put_cnt;
  logic             abort_pend;
  logic             beat;
  logic             wd_expire;

  logic go_r, get_r, stop_r, busy_r, done_r, err_r;

  assign beat = (state == PUT) && bus.put_rdy;

`ifdef WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  // The counter holds the number of idle PUT cycles seen so far, so the
  // TIMEOUT-th idle cycle is the one where it reads TIMEOUT-1.
  assign wd_expire = (state == PUT) && !bus.put_rdy &&
                     (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state != PUT || beat) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // abort_req is ignored here, even together with req
        if (bus.req) state_next = GO;
      end
      GO: begin
        if (bus.abort_req) state_next = ABORT;
        else               state_next = GET;
      end
      GET: begin
        if (bus.abort_req)                             state_next = ABORT;
        else if (get_cnt == CNT_W'(GET_CYCLES - 1))    state_next = PUT;
      end
      PUT: begin
        // A beat and a watchdog expiry cannot coincide (expiry needs !put_rdy)
        if (beat && (put_cnt == CNT_W'(PUT_COUNT - 1))) state_next = DONE;
        else if (wd_expire)                             state_next = ABORT;
      end
      DONE:    state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Phase counters and the latched abort request
  always_ff @(posedge clk) begin
    if (rst) begin
      get_cnt    <= '0;
      put_cnt    <= '0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        GET: begin
          get_cnt <= get_cnt + 1'b1;
        end
        PUT: begin
          if (beat) put_cnt <= put_cnt + 1'b1;
          // Recorded only; a PUT phase always runs to completion
          abort_pend <= abort_pend || bus.abort_req;
        end
        default: begin
          get_cnt    <= '0;
          put_cnt    <= '0;
          abort_pend <= 1'b0;
        end
      endcase
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      go_r   <= 1'b0;
      get_r  <= 1'b0;
      stop_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      go_r   <= (state_next == GO);
      get_r  <= (state_next == GET);
      stop_r <= (state_next == DONE) || (state_next == ABORT);
      busy_r <= (state_next != IDLE);
      done_r <= (state_next == DONE);
      err_r  <= wd_expire;
    end
  end

  assign bus.go   = go_r;
  assign bus.get  = get_r;
  assign bus.put  = beat;
  assign bus.stop = stop_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
`ifdef WATCHDOG_EN
  assign bus.err  = err_r;
`else
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_go_get_put_sequencer.sv
// Directed testbench for go_get_put_sequencer. Each scenario starts from a
// reset pulse; cycle 0 is the first cycle after that reset edge. Outputs
// are packed as {go,get,put,stop,busy,done,err} and sampled on negedge.
module tb_go_get_put_sequencer;

  logic clk = 1'b0;
  logic rst;

  go_get_put_if bus ();

  go_get_put_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] Z     = 7'b0000000;
  localparam logic [6:0] GO_V  = 7'b1000100;
  localparam logic [6:0] GET_V = 7'b0100100;
  localparam logic [6:0] PUT_V = 7'b0010100;
  localparam logic [6:0] BSY   = 7'b0000100;
  localparam logic [6:0] DN    = 7'b0001110;
  localparam logic [6:0] AB    = 7'b0001100;
  localparam logic [6:0] WD    = 7'b0001101;

  logic [6:0] exp_v [32];
  logic [6:0] obs_v [32];
  int checks = 0;
  int passed = 0;

  // Reset, then drive n cycles from per-cycle bit masks and record outputs.
  task automatic run(input int n, input logic [31:0] req_m,
                     input logic [31:0] rdy_m, input logic [31:0] abt_m,
                     input logic [31:0] rst_m);
    @(posedge clk); #1;
    rst = 1'b1; bus.req = 1'b0; bus.put_rdy = 1'b0; bus.abort_req = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < n; c++) begin
      rst           = rst_m[c];
      bus.req       = req_m[c];
      bus.put_rdy   = rdy_m[c];
      bus.abort_req = abt_m[c];
      @(negedge clk);
      obs_v[c] = {bus.go, bus.get, bus.put, bus.stop, bus.busy, bus.done, bus.err};
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.req = 1'b0; bus.put_rdy = 1'b0; bus.abort_req = 1'b0;
  endtask

  task automatic test_reset();
    // put_rdy high right after reset must not produce put in IDLE
    run(2, 32'h0, 32'h3, 32'h3, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_v[i] !== Z)
        $display("FAIL reset cycle %0d: got %b expected %b", i, obs_v[i], Z);
      else passed++;
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    exp_v[4] = PUT_V; exp_v[5] = PUT_V; exp_v[6] = DN; exp_v[7] = Z;
    run(8, 32'h1, 32'hFF, 32'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL basic cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_sparse_put();
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    for (int i = 4; i <= 11; i++) exp_v[i] = BSY;
    exp_v[6] = PUT_V; exp_v[11] = PUT_V; exp_v[12] = DN;
    run(14, 32'h1, (32'h1 << 6) | (32'h1 << 11), 32'h0, 32'h0);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL sparse_put cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_abort_get();
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = AB;
    run(7, 32'h1, 32'h7F, 32'h1 << 2, 32'h0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL abort_get cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_abort_put();
    // abort in PUT (cycle 4) and together with the final beat (cycle 7)
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    exp_v[4] = BSY; exp_v[5] = PUT_V; exp_v[6] = BSY; exp_v[7] = PUT_V;
    exp_v[8] = DN;
    run(10, 32'h1, (32'h1 << 5) | (32'h1 << 7), (32'h1 << 4) | (32'h1 << 7), 32'h0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL abort_put cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    exp_v[6] = GO_V; exp_v[7] = GET_V;
    run(8, 32'h1 | (32'h1 << 5), 32'hFF, 32'h0, 32'h1 << 3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL mid_reset cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    // req held high; abort_req with req in IDLE is ignored
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    exp_v[4] = PUT_V; exp_v[5] = PUT_V; exp_v[6] = DN; exp_v[7] = Z;
    exp_v[8] = GO_V; exp_v[9] = GET_V;
    run(10, 32'h3FF, 32'h3FF, 32'h1 | (32'h1 << 7), 32'h0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL back_to_back cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    for (int i = 4; i <= 18; i++) exp_v[i] = BSY;
    exp_v[19] = WD; exp_v[20] = Z;
    run(22, 32'h1, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 22; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL watchdog cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask
`else
  task automatic test_watchdog();
    // No watchdog: PUT waits through a long idle stretch, err stays low
    for (int i = 0; i < 32; i++) exp_v[i] = Z;
    exp_v[1] = GO_V; exp_v[2] = GET_V; exp_v[3] = GET_V;
    for (int i = 4; i <= 19; i++) exp_v[i] = BSY;
    exp_v[20] = PUT_V; exp_v[21] = PUT_V; exp_v[22] = DN;
    run(24, 32'h1, (32'h1 << 20) | (32'h1 << 21), 32'h0, 32'h0);
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (obs_v[i] !== exp_v[i])
        $display("FAIL no_watchdog cycle %0d: got %b expected %b", i, obs_v[i], exp_v[i]);
      else passed++;
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req = 1'b0;
    bus.put_rdy = 1'b0;
    bus.abort_req = 1'b0;
    test_reset();
    test_basic();
    test_sparse_put();
    test_abort_get();
    test_abort_put();
    test_mid_reset();
    test_back_to_back();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
